// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the MIPS instruction-fetch front end.
package mips_fetch_pkg;

    localparam int          INST_W           = 32;
    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // One queued instruction together with the address it was fetched from.
    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [31:0]       pc;
    } fetch_entry_t;

endpackage

// File: rtl/ifq_fifo.sv
// In-order FIFO of fetch entries. DEPTH must be a power of two (>= 2);
// pointers wrap by masking. Flush empties the queue at the clock edge.
// Push and pop in the same cycle are legal, including when full.
module ifq_fifo
    import mips_fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   push,
    input  fetch_entry_t           din,
    input  logic                   pop,
    output fetch_entry_t           dout,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty
);

    localparam int             AW       = $clog2(DEPTH);
    localparam int             CW       = AW + 1;
    localparam logic [AW-1:0]  PTR_MASK = AW'(DEPTH - 1);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_pop;

    assign empty  = (count == '0);
    assign do_pop = pop & ~empty;
    assign dout   = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; flush behaves like a reset of the control state.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr + 1'b1) & PTR_MASK;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr + 1'b1) & PTR_MASK;
            end
            count <= count + CW'(push) - CW'(do_pop);
        end
    end

    // Entry storage is data only and is never reset.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= din;
        end
    end

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction-fetch front end: prefetches sequential words from imem into
// an in-order queue and hands them one at a time to the core. Redirects
// flush the queue and discard responses that are still in flight.
// Optional macro IFQ_BYPASS_EN: with an empty queue and nothing to drop, an
// incoming response is presented to the core combinationally (0-cycle latency).
module inst_fetch_queue
    import mips_fetch_pkg::*;
#(
    parameter int          DEPTH           = 4,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halted
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);

    logic [31:0]   fetch_pc;
    logic [31:0]   resp_pc;
    logic [31:0]   redirect_addr;
    logic [OW-1:0] outstanding;
    logic [OW-1:0] drop_cnt;
    logic [CW-1:0] count;
    logic          empty;
    fetch_entry_t  head;
    fetch_entry_t  push_entry;
    logic          gnt_fire;
    logic          resp_keep;
    logic          push;
    logic          pop;
    logic [31:0]   credit_used;
    logic          unused_redirect_lo;

    assign redirect_addr      = {redirect_pc[31:2], 2'b00};
    assign unused_redirect_lo = ^redirect_pc[1:0];

    // Slots already spoken for: queued entries plus responses that will be kept.
    assign credit_used = 32'(count) + 32'(outstanding) - 32'(drop_cnt);

    assign imem_req  = !reset && !halted && !redirect_valid
                       && (32'(outstanding) < 32'(MAX_OUTSTANDING))
                       && (credit_used < 32'(DEPTH));
    assign imem_addr = fetch_pc;
    assign gnt_fire  = imem_req & imem_gnt;

    // A response is kept only when nothing remains to be discarded and no redirect is under way.
    assign resp_keep  = imem_rvalid && (drop_cnt == '0) && !redirect_valid;
    assign push_entry = '{inst: imem_rdata, pc: resp_pc};

`ifdef IFQ_BYPASS_EN
    logic bypass;
    assign bypass     = empty && (drop_cnt == '0) && imem_rvalid && !reset;
    assign inst_valid = !empty || bypass;
    assign inst       = !empty ? head.inst : (bypass ? imem_rdata : '0);
    assign inst_pc    = !empty ? head.pc   : (bypass ? resp_pc    : '0);
    // A bypassed word consumed by the core this cycle never enters the queue.
    assign push       = resp_keep && !(bypass && inst_ready);
`else
    assign inst_valid = !empty;
    assign inst       = empty ? '0 : head.inst;
    assign inst_pc    = empty ? '0 : head.pc;
    assign push       = resp_keep;
`endif

    assign pop = !empty && inst_ready && !redirect_valid;

    ifq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .flush (redirect_valid),
        .push  (push),
        .din   (push_entry),
        .pop   (pop),
        .dout  (head),
        .count (count),
        .empty (empty)
    );

    // Fetch/response PCs, in-flight request count and pending-drop count.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            case ({gnt_fire, imem_rvalid})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: ;
            endcase
            if (redirect_valid) begin
                fetch_pc <= redirect_addr;
                resp_pc  <= redirect_addr;
                // Everything still in flight is stale; a response arriving now is discarded directly.
                drop_cnt <= imem_rvalid ? outstanding - 1'b1 : outstanding;
            end else begin
                if (gnt_fire) begin
                    fetch_pc <= fetch_pc + PC_STEP;
                end
                if (resp_keep) begin
                    resp_pc <= resp_pc + PC_STEP;
                end
                if (imem_rvalid && (drop_cnt != '0)) begin
                    drop_cnt <= drop_cnt - 1'b1;
                end
            end
        end
    end

    // Occupancy never exceeds the queue and responses only arrive for issued requests.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (32'(count) <= 32'(DEPTH));
            assert (!(imem_rvalid && (outstanding == '0)));
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue (default build, DEPTH=4, MAX_OUTSTANDING=2).
// Memory responder: grants every request, returns rdata = addr ^ 32'hA5A5_0000
// in order, one cycle after grant unless responses are held back.
`timescale 1ns/1ps
module tb_inst_fetch_queue;

    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halted;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] pend[$];
    logic        hold = 1'b0;

    always #5 clk = ~clk;

    inst_fetch_queue dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halted         (halted)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // One clock: sample the handshake before the edge, drive the response 1ns after it.
    task automatic tick();
        logic        fire;
        logic [31:0] addr;
        #3;
        fire = imem_req & imem_gnt;
        addr = imem_addr;
        @(posedge clk);
        #1;
        if (reset) begin
            pend.delete();
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
        end else begin
            if (fire) pend.push_back(addr);
            if (!hold && pend.size() > 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = pend.pop_front() ^ KEY;
            end else begin
                imem_rvalid = 1'b0;
                imem_rdata  = '0;
            end
        end
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        halted         = 1'b0;
        hold           = 1'b0;
        inst_ready     = 1'b0;
        imem_gnt       = 1'b1;
        tick();
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        inst_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; halted = 1'b0;

        // ---- reset state and sequential stream at full rate
        do_reset();
        chk1("rst_valid", inst_valid, 1'b0);
        chk ("rst_inst", inst, 32'h0);
        chk ("rst_pc", inst_pc, 32'h0);
        chk ("rst_addr", imem_addr, 32'h0);
        chk1("rst_req", imem_req, 1'b0);
        reset = 1'b0; inst_ready = 1'b1;
        tick();
        chk1("s1_e1_valid", inst_valid, 1'b0);
        chk ("s1_e1_addr", imem_addr, 32'h4);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk1("s1_valid", inst_valid, 1'b1);
            chk ("s1_pc", inst_pc, 32'(4 * i));
            chk ("s1_inst", inst, 32'(4 * i) ^ KEY);
        end

        // ---- backpressure: queue fills to DEPTH and fetching stops
        do_reset();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk1("bp_valid", inst_valid, 1'b1);
        chk ("bp_head_pc", inst_pc, 32'h0);
        chk1("bp_req_off", imem_req, 1'b0);
        chk ("bp_addr", imem_addr, 32'h10);
        inst_ready = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk1("bp_drain_valid", inst_valid, 1'b1);
            chk ("bp_drain_pc", inst_pc, 32'(4 * i));
            chk ("bp_drain_inst", inst, 32'(4 * i) ^ KEY);
        end

        // ---- redirect with two requests outstanding
        do_reset();
        reset = 1'b0; inst_ready = 1'b1; hold = 1'b1;
        tick();
        tick();
        chk1("rd_req_full", imem_req, 1'b0);
        chk ("rd_addr_pre", imem_addr, 32'h8);
        redirect_valid = 1'b1; redirect_pc = 32'h0000_0103; hold = 1'b0;
        tick();
        redirect_valid = 1'b0;
        #1;
        chk1("rd_empty", inst_valid, 1'b0);
        chk ("rd_addr", imem_addr, 32'h100);
        chk1("rd_req_wait", imem_req, 1'b0);
        tick();
        chk1("rd_drop1", inst_valid, 1'b0);
        chk1("rd_req_resume", imem_req, 1'b1);
        tick();
        chk1("rd_drop2", inst_valid, 1'b0);
        tick();
        chk1("rd_first_valid", inst_valid, 1'b1);
        chk ("rd_first_pc", inst_pc, 32'h100);
        chk ("rd_first_inst", inst, 32'hA5A5_0100);
        tick();
        chk ("rd_second_pc", inst_pc, 32'h104);

        // ---- redirect coinciding with rvalid, then a second redirect
        do_reset();
        reset = 1'b0; inst_ready = 1'b1; hold = 1'b1;
        tick();
        hold = 1'b0;
        tick();
        redirect_valid = 1'b1; redirect_pc = 32'h40;
        tick();
        redirect_pc = 32'h200;
        #1;
        chk1("rr_req_off", imem_req, 1'b0);
        chk ("rr_addr1", imem_addr, 32'h40);
        chk1("rr_empty1", inst_valid, 1'b0);
        tick();
        redirect_valid = 1'b0;
        #1;
        chk ("rr_addr2", imem_addr, 32'h200);
        chk1("rr_empty2", inst_valid, 1'b0);
        chk1("rr_req_on", imem_req, 1'b1);
        tick();
        chk1("rr_empty3", inst_valid, 1'b0);
        tick();
        chk1("rr_valid", inst_valid, 1'b1);
        chk ("rr_pc0", inst_pc, 32'h200);
        chk ("rr_inst0", inst, 32'hA5A5_0200);
        tick();
        chk ("rr_pc1", inst_pc, 32'h204);

        // ---- halted with one request outstanding
        do_reset();
        reset = 1'b0; hold = 1'b1;
        tick();
        halted = 1'b1; hold = 1'b0;
        #1;
        chk1("h_req_off", imem_req, 1'b0);
        tick();
        chk1("h_not_yet", inst_valid, 1'b0);
        tick();
        chk1("h_valid", inst_valid, 1'b1);
        chk ("h_pc", inst_pc, 32'h0);
        chk ("h_inst", inst, KEY);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk1("h_hold_valid", inst_valid, 1'b1);
            chk1("h_hold_req", imem_req, 1'b0);
        end
        chk ("h_addr", imem_addr, 32'h4);
        halted = 1'b0;

        // ---- address wrap, then reset mid-burst
        do_reset();
        reset = 1'b0; inst_ready = 1'b1;
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        tick();
        redirect_valid = 1'b0;
        #1;
        chk ("w_addr", imem_addr, 32'hFFFF_FFF8);
        tick();
        tick();
        chk ("w_pc0", inst_pc, 32'hFFFF_FFF8);
        chk ("w_inst0", inst, 32'h5A5A_FFF8);
        tick();
        chk ("w_pc1", inst_pc, 32'hFFFF_FFFC);
        chk ("w_inst1", inst, 32'h5A5A_FFFC);
        chk ("w_addr_wrapped", imem_addr, 32'h4);
        tick();
        chk ("w_pc2", inst_pc, 32'h0);
        chk ("w_inst2", inst, KEY);
        reset = 1'b1;
        tick();
        chk1("mr_valid", inst_valid, 1'b0);
        chk ("mr_inst", inst, 32'h0);
        chk ("mr_pc", inst_pc, 32'h0);
        chk ("mr_addr", imem_addr, 32'h0);
        chk1("mr_req", imem_req, 1'b0);
        reset = 1'b0;
        tick();
        chk1("mr_post_valid", inst_valid, 1'b0);
        chk ("mr_post_addr", imem_addr, 32'h4);
        tick();
        chk1("mr_restart_valid", inst_valid, 1'b1);
        chk ("mr_restart_pc", inst_pc, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
